blake_fetch_collector: RTL and testbench

- Downstream of blake_top.
- Drives the blake_top fetch/ack read port and collects the 16-bit odata words of a finished hash into one 256-bit digest register.
- Presents the digest to the host logic with a valid flag.
- Flags a timeout error if blake_top stops acknowledging.

---
 rtl/blake_fetch_collector.sv | 89 ++++++++
 tb/tb_blake_fetch_collector.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/blake_fetch_collector.sv
// Drives the blake_top fetch/ack read port and assembles the odata words into one digest.
// The first word received lands in the digest MSBs; a stalled ack stream raises err.
module blake_fetch_collector #(
  parameter int IOSIZE    = 16,
  parameter int DIGEST_W  = 256,
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                fetch,
  input  logic                ack,
  input  logic [IOSIZE-1:0]   odata,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  output logic                busy,
  output logic                err,
  output logic [4:0]          word_cnt
);

  localparam int NWORDS = DIGEST_W / IOSIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;

  logic last_word;
  logic timed_out;

  assign last_word = (word_cnt == 5'(NWORDS - 1));
  assign timed_out = (wait_cnt == TIMEOUT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      FETCH: begin
        if (ack && last_word)       next_state = DONE;
        else if (!ack && timed_out) next_state = ERR;
      end
      default: begin
        if (start) next_state = FETCH;
      end
    endcase
  end

  // All status outputs decode the state register, so none has a combinational path from ack.
  assign fetch        = (state == FETCH);
  assign busy         = (state == FETCH);
  assign digest_valid = (state == DONE);
  assign err          = (state == ERR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      digest   <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end else if (state == FETCH) begin
      if (ack) begin
        for (int i = 0; i < NWORDS; i++) begin
          if (word_cnt == 5'(i)) digest[DIGEST_W-1-i*IOSIZE -: IOSIZE] <= odata;
        end
        word_cnt <= word_cnt + 5'd1;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      end
    end else if (start) begin
      digest   <= '0;
      word_cnt <= '0;
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_blake_fetch_collector.sv
// Directed bench for blake_fetch_collector: a word-list model is compared on every cycle,
// and literal expectations pin the model at the interesting points.
module tb_blake_fetch_collector;

  localparam int IOSIZE   = 16;
  localparam int DIGEST_W = 256;
  localparam int TIMEOUT  = 8;
  localparam int NWORDS   = DIGEST_W / IOSIZE;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                ack = 1'b0;
  logic [IOSIZE-1:0]   odata = '0;
  logic                fetch;
  logic [DIGEST_W-1:0] digest;
  logic                digest_valid;
  logic                busy;
  logic                err;
  logic [4:0]          word_cnt;

  int checks   = 0;
  int failures = 0;

  blake_fetch_collector #(
    .IOSIZE(IOSIZE), .DIGEST_W(DIGEST_W), .TIMEOUT(TIMEOUT), .TIMEOUT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fetch(fetch), .ack(ack), .odata(odata),
    .digest(digest), .digest_valid(digest_valid), .busy(busy), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 collecting, 2 complete, 3 timed out.
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_idle_run = 0;
  bit          m_init = 1'b0;
  logic [15:0] m_words[NWORDS];

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_idle_run = 0; m_init = 1'b1;
      for (int i = 0; i < NWORDS; i++) m_words[i] = '0;
    end else if (m_phase != 1) begin
      if (start) begin
        m_phase = 1; m_cnt = 0; m_idle_run = 0;
        for (int i = 0; i < NWORDS; i++) m_words[i] = '0;
      end
    end else if (ack) begin
      m_words[m_cnt] = odata;
      m_cnt++;
      m_idle_run = 0;
      if (m_cnt == NWORDS) m_phase = 2;
    end else begin
      m_idle_run++;
      if (m_idle_run == TIMEOUT) m_phase = 3;
    end
  end

  function automatic logic [DIGEST_W-1:0] model_digest();
    logic [DIGEST_W-1:0] d = '0;
    for (int i = 0; i < NWORDS; i++) d = (d << IOSIZE) | DIGEST_W'(m_words[i]);
    return d;
  endfunction

  task automatic check(input string name, input logic [DIGEST_W-1:0] act,
                       input logic [DIGEST_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      check("fetch",        DIGEST_W'(fetch),        DIGEST_W'(m_phase == 1));
      check("busy",         DIGEST_W'(busy),         DIGEST_W'(m_phase == 1));
      check("digest_valid", DIGEST_W'(digest_valid), DIGEST_W'(m_phase == 2));
      check("err",          DIGEST_W'(err),          DIGEST_W'(m_phase == 3));
      check("word_cnt",     DIGEST_W'(word_cnt),     DIGEST_W'(m_cnt));
      check("digest",       digest,                  model_digest());
    end
  end

  // Drive one cycle: inputs change at the falling edge, DUT samples them at the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic a, input logic [IOSIZE-1:0] d);
    rst = r; start = s; ack = a; odata = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset then idle with random ack noise
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    check("rst_digest", digest, '0);
    check("rst_fetch", DIGEST_W'(fetch), '0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1'($urandom_range(0, 1)), 16'($urandom));
    check("idle_word_cnt", DIGEST_W'(word_cnt), '0);

    // Back-to-back collect
    cyc(0, 1, 0, '0);
    check("b2b_fetch_after_start", DIGEST_W'(fetch), 1);
    for (int i = 1; i <= NWORDS; i++) begin
      cyc(0, 0, 1, 16'(i));
      if (i == NWORDS - 1) check("b2b_not_valid_early", DIGEST_W'(digest_valid), 0);
    end
    check("b2b_valid", DIGEST_W'(digest_valid), 1);
    check("b2b_fetch_low", DIGEST_W'(fetch), 0);
    check("b2b_word_cnt", DIGEST_W'(word_cnt), 16);
    check("b2b_digest", digest,
          256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'hFFFF);
    check("done_hold", DIGEST_W'(digest_valid), 1);

    // Stalled acks, gaps of 0..5 idle cycles
    cyc(0, 1, 0, '0);
    for (int i = 0; i < NWORDS; i++) begin
      for (int g = 0; g < i % 6; g++) cyc(0, 0, 0, 16'h0BAD);
      if (i == NWORDS - 1) check("stall_not_valid_early", DIGEST_W'(digest_valid), 0);
      cyc(0, 0, 1, 16'hA5A5 ^ 16'(i));
    end
    check("stall_valid", DIGEST_W'(digest_valid), 1);
    check("stall_err", DIGEST_W'(err), 0);
    check("stall_digest", digest,
          256'hA5A5_A5A4_A5A7_A5A6_A5A1_A5A0_A5A3_A5A2_A5AD_A5AC_A5AF_A5AE_A5A9_A5A8_A5AB_A5AA);

    // Timeout after 3 words
    cyc(0, 1, 0, '0);
    cyc(0, 0, 1, 16'h1111);
    cyc(0, 0, 1, 16'h2222);
    cyc(0, 0, 1, 16'h3333);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cyc(0, 0, 0, '0);
      if (i == TIMEOUT - 1) check("to_err_not_early", DIGEST_W'(err), 0);
    end
    check("to_err", DIGEST_W'(err), 1);
    check("to_fetch", DIGEST_W'(fetch), 0);
    check("to_word_cnt", DIGEST_W'(word_cnt), 3);
    check("to_digest", digest, {48'h1111_2222_3333, 208'h0});
    cyc(0, 0, 1, 16'h4444);
    check("to_err_hold", DIGEST_W'(err), 1);
    cyc(0, 1, 0, '0);
    check("to_restart_err", DIGEST_W'(err), 0);
    check("to_restart_busy", DIGEST_W'(busy), 1);
    check("to_restart_digest", digest, '0);

    // Reset mid-operation after 7 acks, then a full collect
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 16'(16'h7000 + i));
    cyc(1, 0, 0, '0);
    check("midrst_fetch", DIGEST_W'(fetch), 0);
    check("midrst_word_cnt", DIGEST_W'(word_cnt), 0);
    check("midrst_digest", digest, '0);
    cyc(0, 1, 0, '0);
    for (int i = 0; i < NWORDS; i++) cyc(0, 0, 1, 16'(i * 3 + 7));
    check("midrst_recollect_valid", DIGEST_W'(digest_valid), 1);

    // Start during fetch is ignored; rst+start together resets
    cyc(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'(16'hC000 + i));
    cyc(0, 1, 1, 16'hC005);
    check("start_ignored_cnt6", DIGEST_W'(word_cnt), 6);
    cyc(0, 0, 1, 16'hC006);
    check("start_ignored_cnt7", DIGEST_W'(word_cnt), 7);
    cyc(1, 1, 0, '0);
    check("rst_start_fetch", DIGEST_W'(fetch), 0);
    check("rst_start_cnt", DIGEST_W'(word_cnt), 0);
    cyc(0, 0, 1, 16'h1234);
    check("rst_start_idle", DIGEST_W'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
